sid_waveform_tdm: RTL and testbench

//  Time-multiplexed N-voice oscillator/waveform core, the parametrised successor of the per-voice waveform unit.
//  - One shared adder/LFSR datapath serves all voices; per-voice state lives in register arrays.
//  - On each step strobe (one SID cycle), it updates every voice in two sweeps and streams
//    per-voice saw/tri, pulse and noise bits to the waveform mixer.
//  - Sits between the register file and sid_voice/DAC stage.

---
 rtl/sid_waveform_tdm.sv | 186 ++++++++++++++++++
 tb/tb_sid_waveform_tdm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sid_waveform_tdm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sid_waveform_tdm                                                         |
// | Time-multiplexed N-voice SID oscillator / waveform core (shared datapath)|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sid_waveform_tdm #(
   parameter int VOICES    = 3,
   parameter int ACC_W     = 24,
   parameter int FREQ_W    = 16,
   parameter int PW_W      = 12,
   parameter int OUT_W     = 12,
   parameter int LFSR_W    = 23,
   parameter int NOISE_TTL = 33
) (
   input  logic                                          clk,
   input  logic                                          res,
   input  logic                                          tick_ms,
   input  logic                                          step,
   input  logic [VOICES*FREQ_W-1:0]                      freq,
   input  logic [VOICES*PW_W-1:0]                        pw,
   input  logic [VOICES*7-1:0]                           ctrl,
   output logic                                          busy,
   output logic                                          step_miss,
   output logic                                          out_valid,
   output logic [((VOICES > 1) ? $clog2(VOICES) : 1)-1:0] out_voice,
   output logic [3:0]                                    out_sel,
   output logic [OUT_W-1:0]                              out_saw_tri,
   output logic                                          out_pulse,
   output logic [7:0]                                    out_noise
);

   localparam int c_VW    = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam int c_AGE_W = $clog2(NOISE_TTL + 1);
   localparam logic [c_VW-1:0]    c_LAST     = c_VW'(VOICES - 1);
   localparam logic [c_AGE_W-1:0] c_TTL      = c_AGE_W'(NOISE_TTL);
   localparam logic [ACC_W-1:0]   c_OSC_INIT = ACC_W'({((ACC_W + 1) / 2){2'b01}});
   localparam logic [LFSR_W-1:0]  c_TAP_MASK = LFSR_W'(23'h144A25);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_ACC   = 2'd1;
   localparam logic [1:0] c_ST_APPLY = 2'd2;

   function automatic logic [7:0] f_taps(input logic [LFSR_W-1:0] l);
      return {l[20], l[18], l[14], l[11], l[9], l[5], l[2], l[0]};
   endfunction

   logic [1:0]         r_state, w_state_nxt;
   logic [c_VW-1:0]    r_idx;
   logic               r_tick_pend;
   logic [ACC_W-1:0]   r_osc  [VOICES];
   logic [ACC_W-1:0]   r_sum  [VOICES];
   logic [LFSR_W-1:0]  r_lfsr [VOICES];
   logic [c_AGE_W-1:0] r_age  [VOICES];
   logic [VOICES-1:0]  r_msb_new, r_rise, r_pulse_q, r_n_rise, r_test_prev;

   logic w_acc_slot, w_apply_slot, w_last_apply, w_idx_last;

   // per-slot operand selection
   int               w_vi;
   logic [c_VW-1:0]  w_src;
   logic [FREQ_W-1:0] w_freq_v;
   logic [PW_W-1:0]  w_pw_v;
   logic [6:0]       w_ctrl_v;
   logic [ACC_W-1:0] w_osc_v, w_sum;
   logic             w_test;

   assign w_vi     = int'(r_idx);
   assign w_src    = (r_idx == '0) ? c_LAST : r_idx - c_VW'(1);
   assign w_freq_v = freq[w_vi*FREQ_W +: FREQ_W];
   assign w_pw_v   = pw[w_vi*PW_W +: PW_W];
   assign w_ctrl_v = ctrl[w_vi*7 +: 7];
   assign w_test   = w_ctrl_v[0];
   assign w_osc_v  = r_osc[r_idx];
   assign w_sum    = w_osc_v + ACC_W'(w_freq_v);

   // sync/ring and waveform shaping for the APPLY slot
   logic             w_synced, w_msb_eff, w_tri_xor;
   logic [ACC_W-1:0] w_osc_fin;
   logic [OUT_W-1:0] w_saw_tri;

   assign w_synced  = w_test | (w_ctrl_v[1] & r_rise[w_src]);
   assign w_osc_fin = w_synced ? '0 : r_sum[r_idx];
   assign w_msb_eff = r_msb_new[r_idx] & ~w_synced;
   assign w_tri_xor = ~w_ctrl_v[4] & ((w_ctrl_v[2] & ~r_msb_new[w_src]) ^ w_msb_eff);
   assign w_saw_tri = {w_osc_fin[ACC_W-1],
                       w_osc_fin[ACC_W-2 -: OUT_W-1] ^ {(OUT_W-1){w_tri_xor}}};

   logic [LFSR_W-1:0]  w_lfsr_old, w_lfsr_nxt;
   logic [c_AGE_W-1:0] w_age_inc, w_age_nxt;
   logic               w_test_fell, w_refill;

   assign w_lfsr_old  = r_lfsr[r_idx];
   assign w_test_fell = r_test_prev[r_idx] & ~w_test;
   assign w_age_inc   = (r_age[r_idx] == c_TTL) ? r_age[r_idx]
                                                : r_age[r_idx] + c_AGE_W'(r_tick_pend);
   assign w_refill    = w_test & (w_age_inc == c_TTL);

   // refill wins; otherwise shift on bit-19 rise or test release, else combined-waveform clears taps
   always_comb begin
      w_lfsr_nxt = w_lfsr_old;
      w_age_nxt  = w_test ? w_age_inc : '0;
      if (w_refill) begin
         w_lfsr_nxt = '1;
      end else if (w_test_fell || r_n_rise[r_idx]) begin
         w_lfsr_nxt = {w_lfsr_old[LFSR_W-2:0],
                       (w_test_fell | w_lfsr_old[LFSR_W-1]) ^ w_lfsr_old[LFSR_W-6]};
      end else if (w_ctrl_v[6] && (w_ctrl_v[5] || w_ctrl_v[4] || w_ctrl_v[3])) begin
         w_lfsr_nxt = w_lfsr_old & ~c_TAP_MASK;
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) r_state <= c_ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:  if (step)       w_state_nxt = c_ST_ACC;
         c_ST_ACC:   if (w_idx_last) w_state_nxt = c_ST_APPLY;
         c_ST_APPLY: if (w_idx_last) w_state_nxt = c_ST_IDLE;
         default:                    w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      w_idx_last   = (r_idx == c_LAST);
      busy         = (r_state != c_ST_IDLE);
      w_acc_slot   = (r_state == c_ST_ACC);
      w_apply_slot = (r_state == c_ST_APPLY);
      w_last_apply = w_apply_slot & w_idx_last;
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         for (int v = 0; v < VOICES; v++) begin
            r_osc[v]  <= c_OSC_INIT;
            r_sum[v]  <= '0;
            r_lfsr[v] <= '1;
            r_age[v]  <= '0;
         end
         r_msb_new   <= '0;
         r_rise      <= '0;
         r_pulse_q   <= '0;
         r_n_rise    <= '0;
         r_test_prev <= '0;
         r_idx       <= '0;
         r_tick_pend <= 1'b0;
         step_miss   <= 1'b0;
         out_valid   <= 1'b0;
         out_voice   <= '0;
         out_sel     <= '0;
         out_saw_tri <= '0;
         out_pulse   <= 1'b0;
         out_noise   <= '0;
      end else begin
         r_tick_pend <= tick_ms | (r_tick_pend & ~w_last_apply);
         step_miss   <= step & busy;
         out_valid   <= w_apply_slot;
         if (!busy || w_idx_last) r_idx <= '0;
         else                     r_idx <= r_idx + c_VW'(1);
         if (w_acc_slot) begin
            r_sum[r_idx]     <= w_sum;
            r_msb_new[r_idx] <= w_sum[ACC_W-1];
            r_rise[r_idx]    <= ~w_osc_v[ACC_W-1] & w_sum[ACC_W-1] & ~w_test;
            r_pulse_q[r_idx] <= (w_osc_v[ACC_W-1 -: PW_W] >= w_pw_v) | w_test;
            r_n_rise[r_idx]  <= ~w_osc_v[ACC_W-5] & w_sum[ACC_W-5];
         end
         if (w_apply_slot) begin
            r_osc[r_idx]       <= w_osc_fin;
            r_lfsr[r_idx]      <= w_lfsr_nxt;
            r_age[r_idx]       <= w_age_nxt;
            r_test_prev[r_idx] <= w_test;
            out_voice          <= r_idx;
            out_sel            <= w_ctrl_v[6:3];
            out_saw_tri        <= w_saw_tri;
            out_pulse          <= r_pulse_q[r_idx];
            out_noise          <= f_taps(w_lfsr_nxt);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sid_waveform_tdm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sid_waveform_tdm                                                      |
// | Directed self-checking bench for the TDM oscillator/waveform core        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sid_waveform_tdm;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic        tick_ms = 1'b0;
   logic        step = 1'b0;
   logic [47:0] freq = '0;
   logic [35:0] pw = '1;
   logic [20:0] ctrl = '0;
   logic        busy, step_miss, out_valid, out_pulse;
   logic [1:0]  out_voice;
   logic [3:0]  out_sel;
   logic [11:0] out_saw_tri;
   logic [7:0]  out_noise;

   sid_waveform_tdm dut (
      .clk(clk), .res(res), .tick_ms(tick_ms), .step(step),
      .freq(freq), .pw(pw), .ctrl(ctrl),
      .busy(busy), .step_miss(step_miss), .out_valid(out_valid),
      .out_voice(out_voice), .out_sel(out_sel), .out_saw_tri(out_saw_tri),
      .out_pulse(out_pulse), .out_noise(out_noise)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int valid_cnt = 0;
   always @(negedge clk) if (out_valid === 1'b1) valid_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   logic [11:0] cap_st [3];
   logic        cap_pl [3];
   logic [7:0]  cap_nz [3];
   logic [3:0]  cap_sel[3];
   logic [1:0]  cap_order[3];
   int          cap_lat;
   logic        busy_seen;

   task automatic do_reset();
      res = 1'b1;
      freq = '0; pw = '1; ctrl = '0; step = 1'b0; tick_ms = 1'b0;
      @(negedge clk); @(negedge clk);
      res = 1'b0;
   endtask

   task automatic do_step(input bit tick);
      int got;
      @(negedge clk); step = 1'b1; tick_ms = tick;
      @(negedge clk); step = 1'b0; tick_ms = 1'b0;
      busy_seen = busy;
      got = 0; cap_lat = -1;
      for (int i = 1; i <= 20 && got < 3; i++) begin
         if (i > 1) @(negedge clk);
         if (out_valid === 1'b1) begin
            if (cap_lat < 0) cap_lat = i - 1;
            cap_order[got]     = out_voice;
            cap_st[out_voice]  = out_saw_tri;
            cap_pl[out_voice]  = out_pulse;
            cap_nz[out_voice]  = out_noise;
            cap_sel[out_voice] = out_sel;
            got++;
         end
      end
      if (got != 3) check("sweep_timeout", got, 3);
   endtask

   logic [23:0] m0, m1, s0;
   logic        rise;
   int          base;

   initial begin
      // reset state and first sweep
      do_reset();
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_saw_tri", out_saw_tri, 0);
      check("rst_noise", out_noise, 0);
      check("rst_miss", step_miss, 0);
      do_step(0);
      check("busy_in_sweep", busy_seen, 1);
      check("latency", cap_lat, 4);
      check("busy_after", busy, 0);
      for (int v = 0; v < 3; v++) begin
         check("voice_order", cap_order[v], v);
         check("init_saw_tri", cap_st[v], 12'h555);
         check("init_pulse", cap_pl[v], 0);
         check("init_noise", cap_nz[v], 8'hFF);
      end

      // pulse compare boundary, test forcing, combined waveform clearing taps
      pw = {12'hFFF, 12'h556, 12'h555};
      ctrl = {7'h01, 7'h78, 7'h00};
      do_step(0);
      check("pw_equal", cap_pl[0], 1);
      check("pw_above", cap_pl[1], 0);
      check("pw_test", cap_pl[2], 1);
      check("test_osc0", cap_st[2], 12'h000);
      check("sel_v1", cap_sel[1], 4'hF);
      check("comb_noise", cap_nz[1], 8'h00);
      check("test_noise", cap_nz[2], 8'hFF);
      check("comb_saw", cap_st[1], 12'h555);

      // sawtooth ramp with accumulator wrap
      do_reset();
      freq[15:0] = 16'h1000; ctrl[6:0] = 7'h10;
      for (int k = 1; k <= 4096; k++) begin
         do_step(0);
         check("saw_ramp", cap_st[0], (32'h555 + k) & 32'hFFF);
      end

      // hard sync of voice 1 from voice 0
      do_reset();
      freq[15:0] = 16'hFFFF; freq[31:16] = 16'h0100; ctrl[13:7] = 7'h12;
      m0 = 24'h555555; m1 = 24'h555555;
      for (int k = 1; k <= 44; k++) begin
         do_step(0);
         s0 = m0 + 24'h00FFFF;
         rise = ~m0[23] & s0[23];
         m0 = s0;
         m1 = rise ? 24'h0 : m1 + 24'h000100;
         check("sync_model", cap_st[1], m1[23:12]);
         if (k == 42) check("sync_pre", cap_st[1], 12'h557);
         if (k == 43) check("sync_hit", cap_st[1], 12'h000);
      end

      // source held in test never syncs
      do_reset();
      freq[15:0] = 16'hFFFF; freq[31:16] = 16'h0100;
      ctrl[6:0] = 7'h01; ctrl[13:7] = 7'h12;
      for (int k = 1; k <= 50; k++) do_step(0);
      check("nosync_v1", cap_st[1], 12'h558);
      check("nosync_v0", cap_st[0], 12'h000);

      // triangle with ring modulation
      do_reset();
      ctrl[13:7] = 7'h0C;
      do_step(0);
      check("ring_inv", cap_st[1], 12'h2AA);
      ctrl[13:7] = 7'h10;
      do_step(0);
      check("ring_saw_ref", cap_st[1], 12'h555);
      freq[15:0] = 16'hFFFF;
      for (int k = 1; k <= 43; k++) do_step(0);
      freq[15:0] = 16'h0000; ctrl[13:7] = 7'h0C;
      do_step(0);
      check("ring_src_high", cap_st[1], 12'h555);
      check("tri_fold_v0", cap_st[0], 12'hFFA);

      // noise test timeout refill and release shift
      do_reset();
      ctrl[20:14] = 7'h50;
      do_step(0);
      check("noise_clear", cap_nz[2], 8'h00);
      ctrl[20:14] = 7'h51;
      for (int k = 1; k <= 33; k++) begin
         do_step(1);
         if (k == 32) check("noise_hold", cap_nz[2], 8'h00);
      end
      check("noise_refill", cap_nz[2], 8'hFF);
      ctrl[20:14] = 7'h40;
      do_step(0);
      check("noise_release", cap_nz[2], 8'hFE);
      do_step(0);
      check("noise_steady", cap_nz[2], 8'hFE);

      // step while busy
      do_reset();
      @(negedge clk); base = valid_cnt; step = 1'b1;
      @(negedge clk); step = 1'b0;
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      check("miss_pulse", step_miss, 1);
      @(negedge clk);
      check("miss_one_clk", step_miss, 0);
      repeat (16) @(negedge clk);
      check("miss_no_sweep", valid_cnt - base, 3);

      // step at the last APPLY slot
      @(negedge clk); base = valid_cnt; step = 1'b1;
      @(negedge clk); step = 1'b0;
      repeat (5) @(negedge clk);
      step = 1'b1;
      @(negedge clk); step = 1'b0;
      check("miss_last_slot", step_miss, 1);
      check("idle_after_last", busy, 0);
      repeat (12) @(negedge clk);
      check("last_no_sweep", valid_cnt - base, 3);

      // reset in the middle of APPLY
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      repeat (4) @(negedge clk);
      check("valid_pre_rst", out_valid, 1);
      #1 res = 1'b1;
      @(negedge clk);
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_saw", out_saw_tri, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_voice", out_voice, 0);
      res = 1'b0; base = valid_cnt;
      repeat (10) @(negedge clk);
      check("rst_no_partial", valid_cnt - base, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
